// File: rtl/hit_stat_window_scheduler.sv
// Hit-statistics window scheduler: sequences N programmable measurement windows,
// counts hits per window and hands one result per window to readout over valid/ready.
module hit_stat_window_scheduler #(
    parameter int WIN_W  = 20,
    parameter int NWIN_W = 8,
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk40M,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [WIN_W-1:0]  windows,
    input  logic [NWIN_W-1:0] num_windows,
    input  logic [GAP_W-1:0]  gap,
    input  logic              hit,
    output logic              start,
    output logic              stop,
    output logic              win_open,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CNT_W-1:0]  result_count,
    output logic [NWIN_W-1:0] result_index,
    output logic              result_sat,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_CLOSE  = 3'd2,
        ST_REPORT = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]  WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [NWIN_W-1:0] NWIN_ONE = {{(NWIN_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

    state_t              state_r, state_s;
    logic [WIN_W-1:0]    win_len_r, win_len_s;
    logic [NWIN_W-1:0]   num_r, num_s;
    logic [GAP_W-1:0]    gap_len_r, gap_len_s;
    logic [WIN_W-1:0]    win_cnt_r, win_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
    logic [NWIN_W-1:0]   idx_r, idx_s;
    logic [CNT_W-1:0]    hit_cnt_r, hit_cnt_s;
    logic                sat_r, sat_s;
    logic                start_r, start_s;
    logic                stop_r, stop_s;
    logic                win_open_r, win_open_s;
    logic                busy_r, busy_s;
    logic                valid_r, valid_s;
    logic [CNT_W-1:0]    res_count_r, res_count_s;
    logic [NWIN_W-1:0]   res_index_r, res_index_s;
    logic                res_sat_r, res_sat_s;
    logic                done_r, done_s;

    // State, configuration, counters and registered outputs
    always_ff @(posedge clk40M or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            win_len_r   <= '0;
            num_r       <= '0;
            gap_len_r   <= '0;
            win_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            idx_r       <= '0;
            hit_cnt_r   <= '0;
            sat_r       <= 1'b0;
            start_r     <= 1'b0;
            stop_r      <= 1'b0;
            win_open_r  <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            res_count_r <= '0;
            res_index_r <= '0;
            res_sat_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            win_len_r   <= win_len_s;
            num_r       <= num_s;
            gap_len_r   <= gap_len_s;
            win_cnt_r   <= win_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            idx_r       <= idx_s;
            hit_cnt_r   <= hit_cnt_s;
            sat_r       <= sat_s;
            start_r     <= start_s;
            stop_r      <= stop_s;
            win_open_r  <= win_open_s;
            busy_r      <= busy_s;
            valid_r     <= valid_s;
            res_count_r <= res_count_s;
            res_index_r <= res_index_s;
            res_sat_r   <= res_sat_s;
            done_r      <= done_s;
        end
    end

    // Next-state and next-output logic; abort always returns to IDLE on the following cycle
    always_comb begin
        state_s     = state_r;
        win_len_s   = win_len_r;
        num_s       = num_r;
        gap_len_s   = gap_len_r;
        win_cnt_s   = win_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        idx_s       = idx_r;
        hit_cnt_s   = hit_cnt_r;
        sat_s       = sat_r;
        start_s     = 1'b0;
        stop_s      = 1'b0;
        win_open_s  = 1'b0;
        busy_s      = busy_r;
        valid_s     = valid_r;
        res_count_s = res_count_r;
        res_index_s = res_index_r;
        res_sat_s   = res_sat_r;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cmd_abort) begin
                    state_s = ST_IDLE;
                end else if (cmd_start && (windows != '0) && (num_windows != '0)) begin
                    win_len_s  = windows;
                    num_s      = num_windows;
                    gap_len_s  = gap;
                    win_cnt_s  = '0;
                    idx_s      = '0;
                    hit_cnt_s  = '0;
                    sat_s      = 1'b0;
                    start_s    = 1'b1;
                    win_open_s = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = ST_OPEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_OPEN: begin
                // Saturating count; the sticky flag records that at least one hit was lost
                if (hit && win_open_r) begin
                    if (hit_cnt_r == CNT_MAX) begin
                        sat_s = 1'b1;
                    end else begin
                        hit_cnt_s = hit_cnt_r + CNT_ONE;
                    end
                end else begin
                    hit_cnt_s = hit_cnt_r;
                end
                if (cmd_abort) begin
                    stop_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (win_cnt_r == (win_len_r - WIN_ONE)) begin
                    stop_s  = 1'b1;
                    state_s = ST_CLOSE;
                end else begin
                    win_cnt_s  = win_cnt_r + WIN_ONE;
                    win_open_s = 1'b1;
                end
            end

            ST_CLOSE: begin
                if (cmd_abort) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    res_count_s = hit_cnt_r;
                    res_index_s = idx_r;
                    res_sat_s   = sat_r;
                    valid_s     = 1'b1;
                    state_s     = ST_REPORT;
                end
            end

            ST_REPORT: begin
                if (cmd_abort) begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (result_ready) begin
                    valid_s = 1'b0;
                    if (idx_r == (num_r - NWIN_ONE)) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        idx_s     = idx_r + NWIN_ONE;
                        win_cnt_s = '0;
                        hit_cnt_s = '0;
                        sat_s     = 1'b0;
                        gap_cnt_s = '0;
                        if (gap_len_r == '0) begin
                            start_s    = 1'b1;
                            win_open_s = 1'b1;
                            state_s    = ST_OPEN;
                        end else begin
                            state_s = ST_GAP;
                        end
                    end
                end else begin
                    state_s = ST_REPORT;
                end
            end

            ST_GAP: begin
                if (cmd_abort) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (gap_cnt_r == (gap_len_r - GAP_ONE)) begin
                    start_s    = 1'b1;
                    win_open_s = 1'b1;
                    state_s    = ST_OPEN;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end

            default: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign start        = start_r;
    assign stop         = stop_r;
    assign win_open     = win_open_r;
    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign result_count = res_count_r;
    assign result_index = res_index_r;
    assign result_sat   = res_sat_r;
    assign done         = done_r;

endmodule

// File: tb/tb_hit_stat_window_scheduler.sv
// Self-checking bench for hit_stat_window_scheduler: expected start cycles and window
// results are queued when a run is issued and checked as the DUT produces them.
module tb_hit_stat_window_scheduler;

    localparam int WIN_W  = 20;
    localparam int NWIN_W = 8;
    localparam int GAP_W  = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk40M = 1'b0;
    logic              rst_n;
    logic              cmd_start;
    logic              cmd_abort;
    logic [WIN_W-1:0]  windows;
    logic [NWIN_W-1:0] num_windows;
    logic [GAP_W-1:0]  gap;
    logic              hit;
    logic              start;
    logic              stop;
    logic              win_open;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [CNT_W-1:0]  result_count;
    logic [NWIN_W-1:0] result_index;
    logic              result_sat;
    logic              done;

    hit_stat_window_scheduler #(
        .WIN_W(WIN_W), .NWIN_W(NWIN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) dut (
        .clk40M(clk40M), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .windows(windows), .num_windows(num_windows), .gap(gap), .hit(hit),
        .start(start), .stop(stop), .win_open(win_open), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_count(result_count), .result_index(result_index),
        .result_sat(result_sat), .done(done)
    );

    always #12 clk40M = ~clk40M;

    int cyc = 0;
    always @(posedge clk40M) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int cnt;
        int idx;
        int sat;
    } res_t;

    res_t exp_res_q[$];
    int   exp_start_q[$];

    function automatic int hit_at(input int c, input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return c % 2;
        return 0;
    endfunction

    function automatic logic [31:0] out_vec();
        return {7'd0, start, stop, win_open, busy, result_valid, done, result_sat,
                result_count, result_index, 8'd0};
    endfunction

    task automatic run_case(input int w, input int n, input int g, input int mode, input int rdly);
        int   t, p, s, hits, done_exp, last_s, v, nstart, nstop, held_cnt, held_idx;
        bit   fin;
        bit   rdy;
        res_t r;
        @(negedge clk40M);
        t = cyc;
        windows = w; num_windows = n; gap = g; cmd_start = 1'b1;
        hit = hit_at(t, mode);
        result_ready = (rdly == 0);
        p = w + 2 + g + rdly;
        for (int k = 0; k < n; k++) begin
            s = t + 1 + k * p;
            exp_start_q.push_back(s);
            hits = 0;
            for (int c = s; c < s + w; c++) hits += hit_at(c, mode);
            r.cnt = (hits > CMAX) ? CMAX : hits;
            r.idx = k;
            r.sat = (hits > CMAX) ? 1 : 0;
            exp_res_q.push_back(r);
        end
        done_exp = t + 1 + (n - 1) * p + w + 1 + rdly + 1;
        last_s = -100; v = -1; nstart = 0; nstop = 0; fin = 1'b0;
        held_cnt = 0; held_idx = 0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk40M);
            cmd_start = (cyc == t + 2);
            if (cyc == t + 1) begin
                windows = w + 3; num_windows = n + 1; gap = g + 1;
                check("busy_after_accept", busy, 1);
            end
            hit = hit_at(cyc, mode);
            if (start) begin
                nstart++;
                if (exp_start_q.size() > 0) check("start_cycle", cyc, exp_start_q.pop_front());
                else check("extra_start", 1, 0);
                last_s = cyc;
            end
            if (stop) begin
                nstop++;
                check("stop_cycle", cyc, last_s + w);
            end
            if (result_valid) begin
                if (v < 0) begin
                    v = cyc;
                    check("valid_cycle", cyc, last_s + w + 1);
                    held_cnt = result_count;
                    held_idx = result_index;
                end else begin
                    check("hold_count", result_count, held_cnt);
                    check("hold_index", result_index, held_idx);
                    check("hold_no_start", start, 0);
                end
            end
            rdy = (rdly == 0) || (result_valid && v >= 0 && cyc >= v + rdly);
            result_ready = rdy;
            if (result_valid && rdy) begin
                if (exp_res_q.size() > 0) begin
                    r = exp_res_q.pop_front();
                    check("result_count", result_count, r.cnt);
                    check("result_index", result_index, r.idx);
                    check("result_sat", result_sat, r.sat);
                end else begin
                    check("extra_result", 1, 0);
                end
                v = -1;
            end
            if (done) begin
                check("done_cycle", cyc, done_exp);
                check("busy_at_done", busy, 0);
                fin = 1'b1;
            end
        end
        if (!fin) check("timeout_done", 0, 1);
        check("start_count", nstart, n);
        check("stop_count", nstop, n);
        check("results_left", exp_res_q.size(), 0);
        exp_res_q.delete();
        exp_start_q.delete();
        cmd_start = 1'b0;
        result_ready = 1'b1;
        hit = 1'b0;
        repeat (2) @(negedge clk40M);
    endtask

    task automatic abort_case();
        int t, nstart, nstop, nvalid, ndone;
        @(negedge clk40M);
        t = cyc;
        windows = 8; num_windows = 2; gap = 0; cmd_start = 1'b1; hit = 1'b1; result_ready = 1'b1;
        nstart = 0; nstop = 0; nvalid = 0; ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk40M);
            cmd_start = 1'b0;
            cmd_abort = (cyc == t + 3);
            if (start) begin nstart++; check("abort_start_cycle", cyc, t + 1); end
            if (stop)  begin nstop++;  check("abort_stop_cycle", cyc, t + 4); end
            if (result_valid) nvalid++;
            if (done) ndone++;
            if (cyc == t + 4) begin
                check("abort_busy", busy, 0);
                check("abort_win_open", win_open, 0);
            end
        end
        check("abort_nstart", nstart, 1);
        check("abort_nstop", nstop, 1);
        check("abort_nvalid", nvalid, 0);
        check("abort_ndone", ndone, 0);
        hit = 1'b0;
    endtask

    task automatic quiet_case(input string tag, input int w, input int n, input logic ab);
        int act;
        @(negedge clk40M);
        windows = w; num_windows = n; gap = 0; cmd_start = 1'b1; cmd_abort = ab;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk40M);
            cmd_start = 1'b0; cmd_abort = 1'b0;
            if (start || stop || busy || result_valid || done || win_open) act++;
        end
        check(tag, act, 0);
    endtask

    task automatic reset_midrun();
        int act;
        @(negedge clk40M);
        windows = 8; num_windows = 1; gap = 0; cmd_start = 1'b1; hit = 1'b1;
        repeat (3) @(negedge clk40M);
        cmd_start = 1'b0;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_vec(), 0);
        @(negedge clk40M);
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk40M);
            if (start || stop || busy || result_valid || done) act++;
        end
        check("post_reset_quiet", act, 0);
        hit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; windows = '0; num_windows = '0;
        gap = '0; hit = 1'b0; result_ready = 1'b1;
        repeat (3) @(negedge clk40M);
        check("reset_outputs", out_vec(), 0);
        rst_n = 1'b1;
        @(negedge clk40M);
        check("idle_after_reset", out_vec(), 0);

        run_case(5, 1, 0, 1, 0);
        run_case(4, 3, 2, 2, 0);
        run_case(3, 2, 0, 1, 10);
        run_case(20, 1, 0, 1, 0);
        run_case(6, 2, 1, 0, 0);
        run_case(7, 2, 3, 2, 2);
        abort_case();
        quiet_case("ignore_windows0", 0, 3, 1'b0);
        quiet_case("ignore_num0", 5, 0, 1'b0);
        quiet_case("start_abort_same", 5, 1, 1'b1);
        run_case(2, 1, 0, 1, 0);
        reset_midrun();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
